// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind uart_rx: one-shot capture with a registered ack pulse, FWFT consumer port.
// Optional statistics ports (drop count, high-water mark) when UART_RX_FIFO_STATS_EN is defined.
module uart_rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned DATA_W     = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_W-1:0]     i_rx_byte,
  input  logic                  i_rx_valid,
  output logic                  o_rx_ready,
  output logic [DATA_W-1:0]     o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_overflow,
`ifdef UART_RX_FIFO_STATS_EN
  output logic [7:0]            o_drop_count,
  output logic [DEPTH_LOG2:0]   o_high_water,
`endif
  input  logic                  i_clear_overflow
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PtrOne  = 1;
  localparam logic [DEPTH_LOG2:0]   CntOne  = 1;
  localparam logic [DEPTH_LOG2:0]   CntFull = CntOne << DEPTH_LOG2;

  logic [DATA_W-1:0]     mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  lock_q, lock_d;
  logic                  ack_q, ack_d;
  logic                  ovf_q, ovf_d;
  logic                  capture, pop, full, store, drop;

  always_comb begin
    capture = i_rx_valid & ~lock_q;
    pop     = (count_q != '0) & i_ready;
    full    = (count_q == CntFull);
    // A pop frees the slot the write lands in, so a full FIFO still accepts.
    store   = capture & (~full | pop);
    drop    = capture & ~store;

    lock_d   = lock_q;
    if (capture) begin
      lock_d = 1'b1;
    end else if (!i_rx_valid) begin
      lock_d = 1'b0;
    end
    ack_d    = capture;

    wr_ptr_d = store ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrOne : rd_ptr_q;

    count_d = count_q;
    case ({store, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase

    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (i_clear_overflow) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      lock_q   <= 1'b0;
      ack_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      lock_q   <= lock_d;
      ack_q    <= ack_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (store) begin
      mem_q[wr_ptr_q] <= i_rx_byte;
    end
  end

  assign o_rx_ready = ack_q;
  assign o_data     = mem_q[rd_ptr_q];
  assign o_valid    = (count_q != '0);
  assign o_count    = count_q;
  assign o_overflow = ovf_q;

`ifdef UART_RX_FIFO_STATS_EN
  logic [7:0]          drop_cnt_q, drop_cnt_d;
  logic [DEPTH_LOG2:0] hw_q, hw_d;

  always_comb begin
    drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    hw_d       = (count_d > hw_q) ? count_d : hw_q;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      drop_cnt_q <= '0;
      hw_q       <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      hw_q       <= hw_d;
    end
  end

  assign o_drop_count = drop_cnt_q;
  assign o_high_water = hw_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH_LOG2=4).
// Stats checks are compiled in when UART_RX_FIFO_STATS_EN is defined.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic [4:0] count;
  logic       overflow;
  logic       clear_ovf;
`ifdef UART_RX_FIFO_STATS_EN
  logic [7:0] drop_count;
  logic [4:0] high_water;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DEPTH_LOG2(4),
    .DATA_W    (8)
  ) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_rx_byte       (rx_byte),
    .i_rx_valid      (rx_valid),
    .o_rx_ready      (rx_ready),
    .o_data          (data),
    .o_valid         (valid),
    .i_ready         (ready),
    .o_count         (count),
    .o_overflow      (overflow),
`ifdef UART_RX_FIFO_STATS_EN
    .o_drop_count    (drop_count),
    .o_high_water    (high_water),
`endif
    .i_clear_overflow(clear_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle valid pulse followed by one idle cycle so the capture lock re-arms.
  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    rx_byte   = 8'h00;
    rx_valid  = 1'b0;
    ready     = 1'b0;
    clear_ovf = 1'b0;
    tick();
    tick();
    check("reset_valid", valid, 0);
    check("reset_count", count, 0);
    check("reset_ack", rx_ready, 0);
    check("reset_ovf", overflow, 0);
    rst = 1'b0;
    tick();

    // 1: single capture, valid held 3 cycles
    rx_byte  = 8'h41;
    rx_valid = 1'b1;
    check("t1_pre_ack", rx_ready, 0);
    tick();
    check("t1_ack", rx_ready, 1);
    check("t1_valid", valid, 1);
    check("t1_data", data, 8'h41);
    check("t1_count", count, 1);
    tick();
    check("t1_ack_low", rx_ready, 0);
    check("t1_count_held", count, 1);
    tick();
    check("t1_ack_low2", rx_ready, 0);
    check("t1_no_recapture", count, 1);
    rx_valid = 1'b0;
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("t1_pop_count", count, 0);
    check("t1_pop_valid", valid, 0);

    // 2: fill and overflow
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    check("t2_full_count", count, 16);
    check("t2_no_ovf", overflow, 0);
    rx_byte  = 8'hAA;
    rx_valid = 1'b1;
    tick();
    check("t2_drop_ack", rx_ready, 1);
    check("t2_ovf_set", overflow, 1);
    check("t2_count_stuck", count, 16);
    rx_valid = 1'b0;
    tick();
    check("t2_ovf_sticky", overflow, 1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("t2_ovf_clear", overflow, 0);

    // 3: capture into full FIFO with a simultaneous pop
    check("t3_head", data, 8'h00);
    rx_byte  = 8'h55;
    rx_valid = 1'b1;
    ready    = 1'b1;
    tick();
    rx_valid = 1'b0;
    ready    = 1'b0;
    check("t3_count", count, 16);
    check("t3_ovf", overflow, 0);
    check("t3_ack", rx_ready, 1);
    tick();
    ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      check($sformatf("t2_order_%0d", i), data, 32'(i));
      tick();
    end
    check("t3_last", data, 8'h55);
    tick();
    ready = 1'b0;
    check("t3_empty", valid, 0);
    check("t3_empty_count", count, 0);

    // 4: streaming with consumer always ready
    ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rx_byte  = 8'(8'h80 + i);
      rx_valid = 1'b1;
      tick();
      check($sformatf("t4_data_%0d", i), data, 32'(8'h80 + i));
      check($sformatf("t4_cnt1_%0d", i), count, 1);
      rx_valid = 1'b0;
      tick();
      check($sformatf("t4_cnt0_%0d", i), count, 0);
    end
    ready = 1'b0;

    // 5: reset with bytes buffered and ack pending
    for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i));
    rx_byte  = 8'h66;
    rx_valid = 1'b1;
    tick();
    check("t5_pre_count", count, 6);
    check("t5_pre_ack", rx_ready, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", valid, 0);
    check("t5_rst_count", count, 0);
    check("t5_rst_ack", rx_ready, 0);
    tick();
    rst = 1'b0;
    tick();
    check("t5_recapture_count", count, 1);
    check("t5_recapture_data", data, 8'h66);
    check("t5_recapture_ack", rx_ready, 1);
    rx_valid = 1'b0;
    tick();
    send_byte(8'h77);
    check("t5_count2", count, 2);
    ready = 1'b1;
    check("t5_first", data, 8'h66);
    tick();
    check("t5_second", data, 8'h77);
    tick();
    ready = 1'b0;
    check("t5_drained", valid, 0);

`ifdef UART_RX_FIFO_STATS_EN
    // 6: statistics
    check("t6_drop_start", drop_count, 0);
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    check("t6_high_water", high_water, 16);
    for (int i = 0; i < 300; i++) send_byte(8'hEE);
    check("t6_drop_sat", drop_count, 255);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("t6_drop_not_cleared", drop_count, 255);
    check("t6_hw_kept", high_water, 16);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
